// File: rtl/seg7_rx_decoder.sv
// Receive-side seven-segment monitor: synchronizes active-low segment pins, debounces, decodes to a digit.
// Define SEG7_RX_HEX_EN to also accept the hex glyphs A b C d E F as values 10-15.
module seg7_rx_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             seg_A_i,
    input  logic             seg_B_i,
    input  logic             seg_C_i,
    input  logic             seg_D_i,
    input  logic             seg_E_i,
    input  logic             seg_F_i,
    input  logic             seg_G_i,
    input  logic             err_clr_i,
    output logic [3:0]       digit_o,
    output logic             digit_valid_o,
    output logic             digit_stb_o,
    output logic             blank_o,
    output logic             err_o,
    output logic [CNT_W-1:0] change_cnt_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    logic [6:0] r_sync1;
    logic [6:0] r_sync2;
    logic [6:0] r_prev;
    logic [7:0] r_stab;
    logic [1:0] r_state;

    logic [6:0] w_s;
    logic       w_changed;
    logic [7:0] w_stab_next;
    logic       w_accept;
    logic       w_legal;
    logic       w_blank;
    logic [3:0] w_value;

    // Pins are active-low; s is active-high with segment A in the MSB.
    assign w_s       = ~r_sync2;
    assign w_changed = (w_s != r_prev);

    always_comb begin
        w_stab_next = r_stab;
        if (w_changed)
            w_stab_next = 8'd1;
        else if (r_stab < STABLE_MAX)
            w_stab_next = r_stab + 8'd1;
    end

    // A changed pattern can be accepted straight out of LOCKED when STABLE_CYCLES is 1.
    assign w_accept = ((r_state == ST_SETTLE) || ((r_state == ST_LOCKED) && w_changed))
                      && (w_stab_next == STABLE_MAX);

    always_comb begin
        w_legal = 1'b1;
        w_blank = 1'b0;
        w_value = 4'd0;
        case (w_s)
            7'b1111110: w_value = 4'd0;
            7'b0110000: w_value = 4'd1;
            7'b1101101: w_value = 4'd2;
            7'b1111001: w_value = 4'd3;
            7'b0110011: w_value = 4'd4;
            7'b1011011: w_value = 4'd5;
            7'b1011111: w_value = 4'd6;
            7'b1110000: w_value = 4'd7;
            7'b1111111: w_value = 4'd8;
            7'b1111011: w_value = 4'd9;
`ifdef SEG7_RX_HEX_EN
            7'b1110111: w_value = 4'd10;
            7'b0011111: w_value = 4'd11;
            7'b1001110: w_value = 4'd12;
            7'b0111101: w_value = 4'd13;
            7'b1001111: w_value = 4'd14;
            7'b1000111: w_value = 4'd15;
`endif
            7'b0000000: begin
                w_legal = 1'b0;
                w_blank = 1'b1;
            end
            default:    w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync1       <= '1;
            r_sync2       <= '1;
            r_prev        <= '0;
            r_stab        <= '0;
            r_state       <= ST_IDLE;
            digit_o       <= '0;
            digit_valid_o <= 1'b0;
            digit_stb_o   <= 1'b0;
            blank_o       <= 1'b0;
            err_o         <= 1'b0;
            change_cnt_o  <= '0;
        end else begin
            r_sync1     <= {seg_A_i, seg_B_i, seg_C_i, seg_D_i, seg_E_i, seg_F_i, seg_G_i};
            r_sync2     <= r_sync1;
            r_prev      <= w_s;
            digit_stb_o <= 1'b0;

            if (r_state == ST_IDLE) begin
                r_stab  <= '0;
                r_state <= ST_SETTLE;
            end else begin
                r_stab <= w_stab_next;
                if (w_accept)
                    r_state <= ST_LOCKED;
                else if (w_changed)
                    r_state <= ST_SETTLE;
            end

            // Clear first so a coincident illegal accept leaves err_o set.
            if (err_clr_i)
                err_o <= 1'b0;

            if (w_accept) begin
                if (w_blank) begin
                    blank_o       <= 1'b1;
                    digit_valid_o <= 1'b0;
                end else if (w_legal) begin
                    blank_o <= 1'b0;
                    if (!digit_valid_o || (w_value != digit_o)) begin
                        digit_o       <= w_value;
                        digit_valid_o <= 1'b1;
                        digit_stb_o   <= 1'b1;
                        if (change_cnt_o != '1)
                            change_cnt_o <= change_cnt_o + 1'b1;
                    end
                end else begin
                    err_o         <= 1'b1;
                    digit_valid_o <= 1'b0;
                    blank_o       <= 1'b0;
                end
            end
        end
    end

endmodule
